dram_cmd_responder: RTL and testbench
=====================================

# dram_cmd_responder

DIMM-side responder for the memory controller's DRAM command stream. It accepts ACT/PRE/RD/WR commands issued on the DIMM clock and tracks open/idle state and a row for each of the 32 banks (8 bank groups × 4 banks). It enforces tRCD, tRAS, tRP and read-burst spacing, flags each violation, and returns a deterministic read burst CL cycles after every legal RD. It sits at the far end of the scheduler's command output and is the self-checking target for scheduler traces.

## Interface
- TRCD, 39: minimum DIMM cycles from ACT to RD/WR, same bank (1..255)
- TRAS, 76: minimum DIMM cycles from ACT to PRE, same bank (1..255)
- TRP, 39: minimum DIMM cycles from PRE to ACT, same bank (1..255)
- CL, 40: read latency in DIMM cycles (≥2)
- BL, 8: read burst length in beats, one beat per cycle (1..8)
- dimm_clock  in  1  sole clock; everything is sampled on the rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present this cycle
- cmd  in  3  0=ACT, 1=PRE, 2=RD, 3=WR; 4..7 illegal
- cmd_bg  in  3  bank group
- cmd_ba  in  2  bank address
- cmd_row  in  16  row; used by ACT only
- cmd_col  in  10  column; used by RD/WR only
- rd_valid  out  1  read beat valid
- rd_data  out  34  {row[15:0], col[9:0], bg[2:0], ba[1:0], beat[2:0]}
- err_valid  out  1  one-cycle pulse: the previous cycle's command was rejected
- err_code  out  3  violation code (Operation)
- bank_open  out  32  bit {bg,ba} is 1 when that bank is open
- cmd_count  out  32  accepted-command counter; wraps at 2^32

## Operation
- Bank index is {cmd_bg, cmd_ba}. Each bank holds an open flag, a row[15:0] and an 8-bit timer. The timer saturates at 255 and clears to 0 on an accepted ACT or PRE to that bank.
- ACT:
  - bank open -> code 1
  - idle and timer < TRP -> code 5
  - otherwise open the bank and latch cmd_row
- PRE:
  - bank idle -> legal no-op; counted, timer untouched
  - bank open and timer < TRAS -> code 4
  - otherwise close the bank
- RD/WR:
  - bank idle -> code 2
  - bank open and timer < TRCD -> code 3
- RD only: fewer than BL cycles since the last accepted RD (global 4-bit saturating counter) -> code 6. Otherwise the RD is accepted and enters the read pipeline with {open row, cmd_col, bg, ba}.
- WR: accepted with no data; counted only.
- cmd 4..7 -> code 7.
- When several checks fail, the lowest code is reported. A rejected command changes no state and is not counted.
- Accepted commands increment cmd_count. cmd_valid=0 is a NOP.
- Read pipeline:
  - A CL-deep shift register carries the payload.
  - When the payload exits, a beat counter drives BL beats with beat = 0..BL-1.
  - The code-6 rule guarantees bursts never overlap.

## Timing
- A command sampled at edge t updates bank state, bank_open, cmd_count and err_valid/err_code, all visible after edge t. err_valid is high for exactly one cycle.
- Timer semantics: an ACT accepted at edge t allows a RD at edge t+TRCD and rejects it at t+TRCD-1. The same rule applies to TRAS (PRE after ACT) and TRP (ACT after PRE).
- An RD accepted at edge t drives rd_valid from edge t+CL through edge t+CL+BL-1.
- An RD at edge t+BL is legal (back-to-back bursts, rd_valid continuous). An RD at edge t+BL-1 is code 6.
- Reset behaviour:
  - All bank_open=0, rows=0, timers=255, RD-spacing counter saturated.
  - Pipeline cleared; rd_valid=0, rd_data=0, err_valid=0, err_code=0, cmd_count=0.
  - Reset mid-burst aborts the burst on the next edge.
  - A command presented with reset is ignored.
- Each payload read from the bank arrays reflects state before the current edge. A command to the bank whose state is updating at that edge sees the old values; there is no same-cycle forwarding.

## Test plan
- Reset, then ACT bg=2 ba=1 row=0x1234 at cycle 0, RD col=0x05 at cycle 39 -> no error; rd_valid cycles 79..86; first rd_data = {0x1234,0x005,2,1,0}, beat increments to 7; bank_open[9]=1; cmd_count=2.
- ACT at cycle 0, RD same bank at cycle 38 -> err_valid with code 3 after that edge; no rd_valid; cmd_count=1.
- ACT at 0, PRE at 75 -> code 4; PRE at 76 accepted, bank_open bit clears; ACT at 114 -> code 5; ACT at 115 accepted.
- Two RDs to open banks at cycles 100 and 107 -> second gets code 6. Retry at 108 -> accepted; rd_valid continuous for 16 cycles from 140.
- ACT to an already-open bank -> code 1. RD to an idle bank -> code 2. cmd=5 -> code 7. PRE to an idle bank -> no error, cmd_count+1.
- Assert reset at the third beat of a burst -> rd_valid=0, bank_open=0, cmd_count=0 on the next edge. ACT immediately after reset is accepted.

Source files
------------

// File: rtl/dram_cmd_responder.sv
// DIMM-side responder: tracks per-bank open/row/timer state for 32 banks, checks DRAM command
// timing, flags violations and returns a deterministic read burst CL cycles after each legal RD.
module dram_cmd_responder #(
   parameter int unsigned TRCD = 39,
   parameter int unsigned TRAS = 76,
   parameter int unsigned TRP  = 39,
   parameter int unsigned CL   = 40,
   parameter int unsigned BL   = 8
) (
   input  logic        dimm_clock,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic [2:0]  cmd,
   input  logic [2:0]  cmd_bg,
   input  logic [1:0]  cmd_ba,
   input  logic [15:0] cmd_row,
   input  logic [9:0]  cmd_col,
   output logic        rd_valid,
   output logic [33:0] rd_data,
   output logic        err_valid,
   output logic [2:0]  err_code,
   output logic [31:0] bank_open,
   output logic [31:0] cmd_count
);

   localparam int unsigned NumBanks = 32;
   localparam int unsigned PayloadW = 31;

   localparam logic [2:0] CmdAct = 3'd0;
   localparam logic [2:0] CmdPre = 3'd1;
   localparam logic [2:0] CmdRd  = 3'd2;
   localparam logic [2:0] CmdWr  = 3'd3;

   localparam logic [2:0] ErrNone  = 3'd0;
   localparam logic [2:0] ErrOpen  = 3'd1;
   localparam logic [2:0] ErrIdle  = 3'd2;
   localparam logic [2:0] ErrTrcd  = 3'd3;
   localparam logic [2:0] ErrTras  = 3'd4;
   localparam logic [2:0] ErrTrp   = 3'd5;
   localparam logic [2:0] ErrBurst = 3'd6;
   localparam logic [2:0] ErrCmd   = 3'd7;

   // Bank state
   logic [31:0]         open_q, open_d;
   logic [15:0]         row_q   [NumBanks];
   logic [15:0]         row_d   [NumBanks];
   logic [7:0]          timer_q [NumBanks];
   logic [7:0]          timer_d [NumBanks];

   // Global state
   logic [3:0]          rd_gap_q, rd_gap_d;
   logic [31:0]         cnt_q, cnt_d;
   logic                err_valid_q, err_valid_d;
   logic [2:0]          err_code_q, err_code_d;

   // Read pipeline and burst engine
   logic [CL-1:0]       pipe_vld_q, pipe_vld_d;
   logic [PayloadW-1:0] pipe_q [CL];
   logic [PayloadW-1:0] pipe_d [CL];
   logic                burst_q, burst_d;
   logic [2:0]          beat_q, beat_d;
   logic [PayloadW-1:0] burst_pl_q, burst_pl_d;

   // Command decode
   logic [4:0]          idx;
   logic [8:0]          bank_elapsed;
   logic [4:0]          rd_elapsed;
   logic [2:0]          code;
   logic                do_act;
   logic                do_close;
   logic                do_rd;
   logic                accept;

   // Timers hold cycles-since-event minus one, so elapsed = timer + 1 at the sampling edge.
   always_comb begin
      idx          = {cmd_bg, cmd_ba};
      bank_elapsed = {1'b0, timer_q[idx]} + 9'd1;
      rd_elapsed   = {1'b0, rd_gap_q} + 5'd1;
      code         = ErrNone;
      do_act       = 1'b0;
      do_close     = 1'b0;
      do_rd        = 1'b0;
      accept       = 1'b0;
      if (cmd_valid) begin
         case (cmd)
            CmdAct: begin
               if (open_q[idx]) begin
                  code = ErrOpen;
               end else if (bank_elapsed < 9'(TRP)) begin
                  code = ErrTrp;
               end else begin
                  do_act = 1'b1;
               end
            end
            CmdPre: begin
               if (!open_q[idx]) begin
                  accept = 1'b1;
               end else if (bank_elapsed < 9'(TRAS)) begin
                  code = ErrTras;
               end else begin
                  do_close = 1'b1;
               end
            end
            CmdRd, CmdWr: begin
               if (!open_q[idx]) begin
                  code = ErrIdle;
               end else if (bank_elapsed < 9'(TRCD)) begin
                  code = ErrTrcd;
               end else if (cmd == CmdRd && rd_elapsed < 5'(BL)) begin
                  code = ErrBurst;
               end else if (cmd == CmdRd) begin
                  do_rd = 1'b1;
               end else begin
                  accept = 1'b1;
               end
            end
            default: code = ErrCmd;
         endcase
      end
      accept = accept | do_act | do_close | do_rd;
   end

   always_comb begin
      open_d = open_q;
      for (int i = 0; i < NumBanks; i++) begin
         row_d[i]   = row_q[i];
         timer_d[i] = (timer_q[i] == 8'hFF) ? 8'hFF : timer_q[i] + 8'd1;
      end
      if (do_act) begin
         open_d[idx]  = 1'b1;
         row_d[idx]   = cmd_row;
         timer_d[idx] = 8'd0;
      end
      if (do_close) begin
         open_d[idx]  = 1'b0;
         timer_d[idx] = 8'd0;
      end
      if (do_rd) begin
         rd_gap_d = 4'd0;
      end else begin
         rd_gap_d = (rd_gap_q == 4'hF) ? 4'hF : rd_gap_q + 4'd1;
      end
      cnt_d       = cnt_q + {31'd0, accept};
      err_valid_d = (code != ErrNone);
      err_code_d  = code;
   end

   // Payload captures the pre-edge row, so a same-edge ACT to this bank is not forwarded.
   always_comb begin
      pipe_vld_d = {pipe_vld_q[CL-2:0], do_rd};
      pipe_d[0]  = {row_q[idx], cmd_col, cmd_bg, cmd_ba};
      for (int i = 1; i < CL; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      burst_d    = burst_q;
      beat_d     = beat_q;
      burst_pl_d = burst_pl_q;
      if (pipe_vld_q[CL-1]) begin
         burst_d    = 1'b1;
         beat_d     = 3'd0;
         burst_pl_d = pipe_q[CL-1];
      end else if (burst_q && beat_q != 3'(BL - 1)) begin
         beat_d = beat_q + 3'd1;
      end else begin
         burst_d    = 1'b0;
         beat_d     = 3'd0;
         burst_pl_d = '0;
      end
   end

   always_ff @(posedge dimm_clock) begin
      if (reset) begin
         open_q      <= '0;
         for (int i = 0; i < NumBanks; i++) begin
            row_q[i]   <= '0;
            timer_q[i] <= 8'hFF;
         end
         rd_gap_q    <= 4'hF;
         cnt_q       <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ErrNone;
         pipe_vld_q  <= '0;
         burst_q     <= 1'b0;
         beat_q      <= 3'd0;
         burst_pl_q  <= '0;
      end else begin
         open_q      <= open_d;
         for (int i = 0; i < NumBanks; i++) begin
            row_q[i]   <= row_d[i];
            timer_q[i] <= timer_d[i];
         end
         rd_gap_q    <= rd_gap_d;
         cnt_q       <= cnt_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         pipe_vld_q  <= pipe_vld_d;
         burst_q     <= burst_d;
         beat_q      <= beat_d;
         burst_pl_q  <= burst_pl_d;
      end
   end

   // Payload stages are qualified by pipe_vld_q and need no reset.
   always_ff @(posedge dimm_clock) begin
      for (int i = 0; i < CL; i++) begin
         pipe_q[i] <= pipe_d[i];
      end
   end

   assign rd_valid  = burst_q;
   assign rd_data   = {burst_pl_q, beat_q};
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign bank_open = open_q;
   assign cmd_count = cnt_q;

endmodule

// File: tb/tb_dram_cmd_responder.sv
// Directed bench for dram_cmd_responder: commands checked at issue, read beats checked against a
// scoreboard of expected (edge, data) entries.
module tb_dram_cmd_responder;

   localparam int unsigned CL = 40;
   localparam int unsigned BL = 8;

   localparam logic [2:0] ACT = 3'd0;
   localparam logic [2:0] PRE = 3'd1;
   localparam logic [2:0] RD  = 3'd2;
   localparam logic [2:0] WR  = 3'd3;

   logic        dimm_clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic [2:0]  cmd;
   logic [2:0]  cmd_bg;
   logic [1:0]  cmd_ba;
   logic [15:0] cmd_row;
   logic [9:0]  cmd_col;
   logic        rd_valid;
   logic [33:0] rd_data;
   logic        err_valid;
   logic [2:0]  err_code;
   logic [31:0] bank_open;
   logic [31:0] cmd_count;

   dram_cmd_responder #(
      .TRCD(39), .TRAS(76), .TRP(39), .CL(CL), .BL(BL)
   ) dut (
      .dimm_clock(dimm_clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd       (cmd),
      .cmd_bg    (cmd_bg),
      .cmd_ba    (cmd_ba),
      .cmd_row   (cmd_row),
      .cmd_col   (cmd_col),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .err_valid (err_valid),
      .err_code  (err_code),
      .bank_open (bank_open),
      .cmd_count (cmd_count)
   );

   always #5 dimm_clock = ~dimm_clock;

   typedef struct {
      int          e;
      logic [33:0] d;
   } beat_t;

   beat_t sb[$];
   int    ec      = 0;
   int    n_tests = 0;
   int    n_fail  = 0;
   int    exp_cnt = 0;

   always @(posedge dimm_clock) ec <= ec + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Beat for edge e is visible between edge e and edge e+1.
   always @(negedge dimm_clock) begin : mon
      logic exp_v;
      if (!reset) begin
         while (sb.size() > 0 && sb[0].e < ec) begin
            chk("rd_beat_missed_edge", 64'(sb[0].e), 64'(ec));
            void'(sb.pop_front());
         end
         exp_v = (sb.size() > 0) && (sb[0].e == ec);
         if (rd_valid !== 1'b0 || exp_v) begin
            chk("rd_valid", {63'd0, rd_valid}, {63'd0, exp_v});
            if (exp_v) begin
               chk("rd_data", {30'd0, rd_data}, {30'd0, sb[0].d});
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge dimm_clock);
      #1;
   endtask

   // For RD, row is the bench's expectation of the bank's open row (the DUT ignores cmd_row).
   task automatic issue(input string tag, input logic [2:0] c, input logic [2:0] bg,
                        input logic [1:0] ba, input logic [15:0] row, input logic [9:0] col,
                        input logic [2:0] code);
      int    e;
      beat_t b;
      e = ec + 1;
      if (c == RD && code == 3'd0) begin
         for (int k = 0; k < int'(BL); k++) begin
            b.e = e + int'(CL) + k;
            b.d = {row, col, bg, ba, 3'(k)};
            sb.push_back(b);
         end
      end
      cmd_valid = 1'b1;
      cmd       = c;
      cmd_bg    = bg;
      cmd_ba    = ba;
      cmd_row   = row;
      cmd_col   = col;
      @(posedge dimm_clock);
      #1;
      cmd_valid = 1'b0;
      if (code == 3'd0) exp_cnt++;
      chk({tag, "_err_valid"}, {63'd0, err_valid}, {63'd0, (code != 3'd0)});
      if (code != 3'd0) chk({tag, "_err_code"}, {61'd0, err_code}, {61'd0, code});
      chk({tag, "_count"}, {32'd0, cmd_count}, 64'(exp_cnt));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd       = '0;
      cmd_bg    = '0;
      cmd_ba    = '0;
      cmd_row   = '0;
      cmd_col   = '0;
      idle(2);
      reset = 1'b0;
      chk("rst_bank_open", {32'd0, bank_open}, 64'd0);
      chk("rst_count", {32'd0, cmd_count}, 64'd0);
      chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("rst_rd_data", {30'd0, rd_data}, 64'd0);
      chk("rst_err_valid", {63'd0, err_valid}, 64'd0);
      chk("rst_err_code", {61'd0, err_code}, 64'd0);

      // ACT -> RD one cycle early (code 3), then exactly at tRCD
      issue("act9", ACT, 3'd2, 2'd1, 16'h1234, 10'd0, 3'd0);
      chk("open9", {63'd0, bank_open[9]}, 64'd1);
      idle(37);
      issue("rd9_early", RD, 3'd2, 2'd1, 16'h1234, 10'h005, 3'd3);
      issue("rd9_ok", RD, 3'd2, 2'd1, 16'h1234, 10'h005, 3'd0);
      chk("err_pulse_one_cycle", {63'd0, err_valid}, 64'd0);
      idle(CL + BL + 2);

      // tRAS and tRP boundaries on bank 0
      issue("act0", ACT, 3'd0, 2'd0, 16'h0ABC, 10'd0, 3'd0);
      idle(74);
      issue("pre0_early", PRE, 3'd0, 2'd0, 16'd0, 10'd0, 3'd4);
      issue("pre0_ok", PRE, 3'd0, 2'd0, 16'd0, 10'd0, 3'd0);
      chk("closed0", {63'd0, bank_open[0]}, 64'd0);
      idle(37);
      issue("act0_early", ACT, 3'd0, 2'd0, 16'hBEEF, 10'd0, 3'd5);
      issue("act0_ok", ACT, 3'd0, 2'd0, 16'hBEEF, 10'd0, 3'd0);
      chk("open0", {63'd0, bank_open[0]}, 64'd1);

      // Read spacing: +7 rejected, +8 accepted with continuous beats
      idle(40);
      issue("rd_a", RD, 3'd2, 2'd1, 16'h1234, 10'h3FF, 3'd0);
      idle(6);
      issue("rd_b_early", RD, 3'd0, 2'd0, 16'hBEEF, 10'h155, 3'd6);
      issue("rd_b_ok", RD, 3'd0, 2'd0, 16'hBEEF, 10'h155, 3'd0);
      idle(CL + 2 * BL + 2);

      // Remaining error codes and priority
      issue("act_open", ACT, 3'd2, 2'd1, 16'h7777, 10'd0, 3'd1);
      issue("rd_idle", RD, 3'd7, 2'd3, 16'd0, 10'd1, 3'd2);
      issue("illegal", 3'd5, 3'd1, 2'd2, 16'd0, 10'd0, 3'd7);
      issue("pre_idle", PRE, 3'd7, 2'd3, 16'd0, 10'd0, 3'd0);
      issue("wr9", WR, 3'd2, 2'd1, 16'd0, 10'h2A, 3'd0);
      issue("rd_c", RD, 3'd2, 2'd1, 16'h1234, 10'h0F0, 3'd0);
      issue("rd_idle_prio", RD, 3'd7, 2'd3, 16'd0, 10'd0, 3'd2);
      issue("rd_spacing", RD, 3'd2, 2'd1, 16'h1234, 10'd0, 3'd6);
      chk("row_kept", {63'd0, bank_open[9]}, 64'd1);
      idle(CL + BL + 2);

      // Reset during the third beat; command presented with reset is ignored
      issue("rd_d", RD, 3'd0, 2'd0, 16'hBEEF, 10'h011, 3'd0);
      idle(CL + 2);
      reset     = 1'b1;
      cmd_valid = 1'b1;
      cmd       = ACT;
      cmd_bg    = 3'd3;
      cmd_ba    = 2'd3;
      @(posedge dimm_clock);
      #1;
      sb.delete();
      reset     = 1'b0;
      cmd_valid = 1'b0;
      exp_cnt   = 0;
      chk("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
      chk("mid_rst_rd_data", {30'd0, rd_data}, 64'd0);
      chk("mid_rst_bank_open", {32'd0, bank_open}, 64'd0);
      chk("mid_rst_count", {32'd0, cmd_count}, 64'd0);
      chk("mid_rst_err_valid", {63'd0, err_valid}, 64'd0);
      issue("act_after_rst", ACT, 3'd1, 2'd1, 16'h5555, 10'd0, 3'd0);
      chk("open5", {63'd0, bank_open[5]}, 64'd1);
      idle(CL + BL + 2);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
